// File: rtl/chip8_pkg.sv
// Shared types for the CHIP-8 keypad wait/skip block. Optional release-wait
// behaviour is selected with CHIP8_KEY_RELEASE_WAIT_EN.
package chip8_pkg;

  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_KEYS = 16;

  typedef enum logic [1:0] {
    OP_WAIT_KEY = 2'b00,
    OP_SKP      = 2'b01,
    OP_SKNP     = 2'b10,
    OP_RSVD     = 2'b11
  } key_op_e;

  typedef enum logic [1:0] {
    StIdle        = 2'b00,
    StWaitPress   = 2'b01,
    StWaitRelease = 2'b10,
    StResp        = 2'b11
  } wait_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [KEY_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
    lowest_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) lowest_key = i[KEY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/chip8_key_debounce.sv
// Keypad debouncer: the debounced vector follows the registered raw vector once
// it has been unchanged for DEBOUNCE_CYCLES consecutive cycles.
module chip8_key_debounce
  import chip8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] raw,
  output logic [NUM_KEYS-1:0] debounced
);

  localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0] sample_q;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [7:0]          cnt_q, cnt_d;

  // cnt_q counts how many consecutive samples sample_q has held its value.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (raw != sample_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (cnt_q == CntMax) begin
      deb_d = sample_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      cnt_q    <= '0;
      deb_q    <= '0;
    end else begin
      sample_q <= raw;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/chip8_key_wait.sv
// CHIP-8 keypad unit serving FX0A / EX9E / EXA1. Define CHIP8_KEY_RELEASE_WAIT_EN
// to make FX0A complete on release of the captured key instead of on the press.
module chip8_key_wait
  import chip8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_state,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [KEY_W-1:0]    req_key,
  input  logic                abort,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [KEY_W-1:0]    rsp_key,
  output logic                rsp_skip,
  output logic                busy
);

  // Assertion is asynchronous, release reaches the logic two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic [NUM_KEYS-1:0] debounced;

  chip8_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (key_state),
    .debounced(debounced)
  );

  wait_state_e         state_q, state_d;
  logic [NUM_KEYS-1:0] baseline_q, baseline_d;
  logic [KEY_W-1:0]    rsp_key_q, rsp_key_d;
  logic                rsp_skip_q, rsp_skip_d;
  logic [NUM_KEYS-1:0] fresh;
  key_op_e             op;
`ifdef CHIP8_KEY_RELEASE_WAIT_EN
  logic [KEY_W-1:0]    pend_q, pend_d;
`endif

  assign op    = key_op_e'(req_op);
  assign fresh = debounced & ~baseline_q;

  always_comb begin
    state_d    = state_q;
    baseline_d = baseline_q;
    rsp_key_d  = rsp_key_q;
    rsp_skip_d = rsp_skip_q;
`ifdef CHIP8_KEY_RELEASE_WAIT_EN
    pend_d     = pend_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          unique case (op)
            OP_WAIT_KEY: begin
              baseline_d = debounced;
              state_d    = StWaitPress;
            end
            OP_SKP, OP_SKNP: begin
              rsp_key_d  = req_key;
              rsp_skip_d = debounced[req_key] ^ (op == OP_SKNP);
              state_d    = StResp;
            end
            default: ;  // reserved op is consumed silently
          endcase
        end
      end
      StWaitPress: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          // Keys held at accept only count once they have been released.
          baseline_d = baseline_q & debounced;
          if (|fresh) begin
`ifdef CHIP8_KEY_RELEASE_WAIT_EN
            pend_d  = lowest_key(fresh);
            state_d = StWaitRelease;
`else
            rsp_key_d  = lowest_key(fresh);
            rsp_skip_d = 1'b0;
            state_d    = StResp;
`endif
          end
        end
      end
      StWaitRelease: begin
`ifdef CHIP8_KEY_RELEASE_WAIT_EN
        if (abort) begin
          state_d = StIdle;
        end else if (!debounced[pend_q]) begin
          rsp_key_d  = pend_q;
          rsp_skip_d = 1'b0;
          state_d    = StResp;
        end
`else
        state_d = StIdle;
`endif
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baseline_q <= '0;
      rsp_key_q  <= '0;
      rsp_skip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baseline_q <= baseline_d;
      rsp_key_q  <= rsp_key_d;
      rsp_skip_q <= rsp_skip_d;
    end
  end

`ifdef CHIP8_KEY_RELEASE_WAIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_key   = rsp_key_q;
  assign rsp_skip  = rsp_skip_q;

endmodule

// File: doc/chip8_key_wait.md
CHIP8_KEY_WAIT -- requirements
Module: chip8_key_wait

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive cycles key_state must be unchanged before the debounced vector updates (legal range 1..255).
REQ-002 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset.
REQ-004 Port: key_state, input, 16, raw per-key level from the keypad scanner; bit i = key i held.
REQ-005 Port: req_valid, input, 1, CPU key-operation request valid.
REQ-006 Port: req_ready, output, 1, block can accept a request.
REQ-007 Port: req_op, input, 2, operation: 00 = FX0A wait-for-key; 01 = EX9E skip-if-pressed; 10 = EXA1 skip-if-not-pressed; 11 = reserved.
REQ-008 Port: req_key, input, 4, key index for EX9E/EXA1; ignored for FX0A.
REQ-009 Port: abort, input, 1, cancels an outstanding FX0A wait.
REQ-010 Port: rsp_valid, output, 1, response valid.
REQ-011 Port: rsp_ready, input, 1, CPU accepts response.
REQ-012 Port: rsp_key, output, 4, resolved key index.
REQ-013 Port: rsp_skip, output, 1, skip decision for EX9E/EXA1; 0 for FX0A.
REQ-014 Port: busy, output, 1, high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, WAIT_PRESS, WAIT_RELEASE, RESP; req_ready SHALL equal (state == IDLE).
REQ-016 Debounce: key_state is registered; the debounced vector SHALL take the registered value after it has been identical for DEBOUNCE_CYCLES consecutive cycles; the stability counter saturates and restarts on any change.
REQ-017 All decisions SHALL use only the debounced vector, never raw key_state.
REQ-018 IDLE, handshake with op 01/10: next state RESP; rsp_key = req_key; rsp_skip = debounced[req_key] for 01, its inverse for 10; rsp_valid rises on the next cycle.
REQ-019 IDLE, handshake with op 11: request is consumed, no response, state stays IDLE.
REQ-020 IDLE, handshake with op 00: baseline := debounced; next state WAIT_PRESS.
REQ-021 WAIT_PRESS: each cycle baseline &= debounced (released keys are cleared); new = debounced & ~baseline; if new != 0, capture the lowest set index as the pending key.
REQ-022 Keys already held when FX0A is accepted SHALL NOT satisfy the wait until released and pressed again.
REQ-023 On capture, next state is WAIT_RELEASE (macro defined) or RESP (macro undefined).
REQ-024 WAIT_RELEASE: go to RESP when debounced[pending key] = 0; other keys are ignored.
REQ-025 RESP: rsp_valid = 1 and rsp_key/rsp_skip held stable until rsp_valid && rsp_ready, then IDLE in the same cycle as the handshake.
REQ-026 abort in WAIT_PRESS or WAIT_RELEASE: IDLE next cycle, no response. abort in IDLE or RESP is ignored. If abort and capture occur in the same cycle, abort wins.
REQ-027 A new request SHALL NOT be accepted in the cycle a response handshake completes.

Reset
REQ-028 On reset low: state IDLE, req_ready 1, rsp_valid 0, rsp_key 0, rsp_skip 0, busy 0, debounced 0, baseline 0, stability counter 0; takes effect immediately, including mid-wait.
REQ-029 Reset deassertion SHALL be synchronised internally; the first request is accepted no earlier than the second clk edge after deassertion.

Configuration
REQ-030 Macro CHIP8_KEY_RELEASE_WAIT_EN defined: FX0A completes on release of the captured key (COSMAC behaviour).
REQ-031 Macro CHIP8_KEY_RELEASE_WAIT_EN undefined: WAIT_RELEASE is not built; FX0A completes on the press; the state encoding is otherwise unchanged.

Structure
REQ-032 Shared package chip8_pkg SHALL hold the op encodings (OP_WAIT_KEY, OP_SKP, OP_SKNP), the state enum, and KEY_W = 4 / NUM_KEYS = 16.
REQ-033 Debounce SHALL be the sub-module chip8_key_debounce (parameter DEBOUNCE_CYCLES; in 16, out 16).

Verification
REQ-034 DEBOUNCE_CYCLES=4; key_state=0x0020 for 3 cycles then 0 -> debounced stays 0; held 4+ cycles -> debounced=0x0020.
REQ-035 EX9E with req_key=5, debounced=0x0020 -> rsp_valid one cycle after accept, rsp_key=5, rsp_skip=1; EXA1 with the same key -> rsp_skip=0.
REQ-036 Key 3 held, FX0A issued, then key 0xA pressed -> rsp_key=0xA; key 3 is never reported.
REQ-037 Macro defined; FX0A, keys 2 and 7 pressed in the same cycle -> pending=2; rsp_valid only after key 2 debounces low; with the macro undefined, rsp_valid follows the press.
REQ-038 FX0A waiting, abort=1 together with a key press -> IDLE, no rsp_valid, req_ready=1 next cycle.
REQ-039 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_key stable throughout; reset low during WAIT_PRESS -> all outputs at reset values immediately.
